single_multiply_arbiter: RTL and testbench
==========================================

Name: single_multiply_arbiter

Overview:
- Shares one `single_multiply` instance (2-cycle, fully pipelined, 1 op/cycle) between N_REQ requesters.
- Round-robin arbitration; registers the winning operands onto the multiplier inputs.
- Tracks requester ID through a tag pipeline matched to the multiplier latency, and routes each product back to its originator.
- Also generates the multiplier's synchronous active-low reset from the system reset.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MUL_LATENCY, 2, cycles from mul_in_valid to mul_out_valid of the multiplier.
- RST_HOLD, 2, cycles mul_rstn stays low after rst deasserts; must be ≥ MUL_LATENCY.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_ready  out  N_REQ  per-requester grant (handshake = valid & ready).
- req_a  in  32*N_REQ  operand A, IEEE single; requester i at [32i+31:32i].
- req_b  in  32*N_REQ  operand B, same packing.
- res_valid  out  N_REQ  one-hot result strobe, 1 cycle, no backpressure.
- res_data  out  32  product for the strobed requester.
- mul_rstn  out  1  to multiplier rstn.
- mul_in_valid  out  1  to multiplier in_valid.
- mul_a  out  32  to multiplier a.
- mul_b  out  32  to multiplier b.
- mul_out_valid  in  1  from multiplier out_valid.
- mul_c  in  32  from multiplier c.
- err  out  1  sticky tag/valid mismatch flag.

Behaviour:
- Reset (rst high, async): all outputs 0 (req_ready, res_valid, res_data, mul_rstn, mul_in_valid, mul_a, mul_b, err); RR pointer = 0; tag pipeline cleared; hold counter = RST_HOLD.
- After rst deasserts: mul_rstn stays 0 for exactly RST_HOLD clocks, then registers to 1. Meanwhile req_ready = 0 and mul_in_valid = 0, so the multiplier's unreset valid pipeline flushes.
- Arbitration (combinational req_ready, only when mul_rstn = 1):
  - Search req_valid from index ptr upward, wrapping mod N_REQ.
  - First set bit gets req_ready; at most one grant per cycle.
  - On grant to i: ptr ← (i+1) mod N_REQ. No valid requests: ptr unchanged.
- Issue register: on grant in cycle t, at t+1 mul_in_valid = 1, mul_a/mul_b = granted operands. Without a grant, mul_in_valid = 0 and mul_a/mul_b hold their last value.
- Tag pipeline:
  - Depth MUL_LATENCY of {valid, id}, entered from the issue stage, shifts every cycle.
  - Stage MUL_LATENCY aligns with mul_out_valid/mul_c, at t+1+MUL_LATENCY.
- Result register: when the tag-tail valid is 1, at the next cycle res_valid[id] = 1 and res_data = mul_c; otherwise res_valid = 0 and res_data holds.
  - Total latency grant→res_valid = MUL_LATENCY+2 (4 by default).
  - Throughput 1 result/cycle; results return in issue order.
- Tag-tail valid is authoritative; mul_out_valid is used only for checking.
- err: set when mul_rstn = 1 and mul_out_valid ≠ tag-tail valid; cleared only by rst.
- Same requester may be granted on consecutive cycles only if it is the sole valid requester.
- Requester may drop req_valid without a grant; no state changes.
- rst asserted mid-operation: in-flight tags discarded; no res_valid is ever emitted for ops issued before reset.
- No arithmetic in this block; products are exactly the multiplier's c (zero-operand and exponent-wrap behaviour inherited).

Test Plan:
- Reset release: rst 1→0 → mul_rstn low for exactly 2 clocks; req_ready = 0 during hold even with req_valid = 4'b1111; err stays 0.
- Single op: requester 2, a = 0x40400000, b = 0x40000000, granted cycle t → res_valid = 4'b0100, res_data = 0x40C00000 at t+4; no other strobes.
- Full contention: req_valid = 4'b1111 held 8 cycles from ptr = 0 → grants 0,1,2,3,0,1,2,3 on consecutive cycles. Distinct operands (k+1.0 × 2.0) return 0x40000000, 0x40800000, 0x40C00000, 0x41000000 in matching order, one per cycle.
- Zero and sparse: requester 1 sends 0x00000000 × 0x40400000, requester 3 sends 0xBF800000 × 0x3F800000 with an idle cycle between → res_data 0x00000000 then 0xBF800000; ptr skips idle requesters.
- Reset mid-flight: grants in cycles t, t+1, then rst asserted at t+2 → no res_valid afterwards; after release, a new op completes with correct id and latency 4.
- Checker: force mul_out_valid = 1 for one cycle with an empty tag pipeline → err = 1 next cycle and stays 1 until rst.

Source files
------------

// File: rtl/single_multiply_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : single_multiply_arbiter
// Description : Round-robin sharing of one pipelined single-precision
//               multiplier between N_REQ requesters. Registers the winning
//               operands onto the multiplier, carries the requester id through
//               a tag pipeline matched to the multiplier latency, steers each
//               product back to its originator, and sequences the multiplier's
//               synchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module single_multiply_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MUL_LATENCY = 2,
  parameter int RST_HOLD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      res_valid,
  output logic [31:0]           res_data,
  output logic                  mul_rstn,
  output logic                  mul_in_valid,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic                  mul_out_valid,
  input  logic [31:0]           mul_c,
  output logic                  err
);

  localparam int C_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int C_CNT_W = $clog2(RST_HOLD + 1);

  // Reset sequencer states: HOLD keeps the multiplier in reset while its
  // unreset valid pipeline drains; RUN enables arbitration.
  localparam logic [0:0] S_HOLD = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [C_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic               run_w;

  // Arbitration
  logic [C_PTR_W-1:0] ptr_q, ptr_d;
  logic               grant_w;
  logic [C_PTR_W-1:0] grant_idx_w;
  logic [31:0]        req_a_arr [N_REQ];
  logic [31:0]        req_b_arr [N_REQ];

  // Issue stage
  logic               issue_v_q;
  logic [C_PTR_W-1:0] issue_id_q;
  logic [31:0]        mul_a_q, mul_b_q;

  // Tag pipeline, stage k aligns with multiplier stage k
  logic               tag_v_q  [1:MUL_LATENCY];
  logic [C_PTR_W-1:0] tag_id_q [1:MUL_LATENCY];
  logic               tail_v_w;
  logic [C_PTR_W-1:0] tail_id_w;
  logic [N_REQ-1:0]   tail_onehot_w;

  // Result and checker
  logic [N_REQ-1:0]   res_valid_q;
  logic [31:0]        res_data_q;
  logic               err_q;

  // --------------------------------------------------------------------------
  // Reset sequencer
  // --------------------------------------------------------------------------

  // State register for the multiplier reset sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HOLD;
      hold_cnt_q <= C_CNT_W'(RST_HOLD);
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next state: count down the hold window, then stay in RUN until rst.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_HOLD: begin
        if (hold_cnt_q <= C_CNT_W'(1)) begin
          state_d    = S_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - C_CNT_W'(1);
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_HOLD;
    endcase
  end

  // Outputs: the multiplier leaves reset exactly when arbitration is enabled.
  always_comb begin
    run_w    = (state_q == S_RUN);
    mul_rstn = run_w;
  end

  // --------------------------------------------------------------------------
  // Round-robin arbitration
  // --------------------------------------------------------------------------

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_a_arr[gi] = req_a[32*gi +: 32];
      assign req_b_arr[gi] = req_b[32*gi +: 32];
    end
  endgenerate

  // Search upward from the pointer, wrapping, and pick the first valid request.
  always_comb begin
    logic [C_PTR_W:0] idx;
    grant_w     = 1'b0;
    grant_idx_w = '0;
    idx         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_q} + (C_PTR_W+1)'(k);
      if (idx >= (C_PTR_W+1)'(N_REQ)) begin
        idx = idx - (C_PTR_W+1)'(N_REQ);
      end
      if (!grant_w && run_w && req_valid[idx[C_PTR_W-1:0]]) begin
        grant_w     = 1'b1;
        grant_idx_w = idx[C_PTR_W-1:0];
      end
    end
  end

  // One-hot ready for the winner; the pointer moves just past the winner.
  always_comb begin
    req_ready = '0;
    ptr_d     = ptr_q;
    if (grant_w) begin
      req_ready[grant_idx_w] = 1'b1;
      if (grant_idx_w == C_PTR_W'(N_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx_w + C_PTR_W'(1);
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Issue register: operands hold their last value when nothing is granted
  // --------------------------------------------------------------------------

  // Capture the granted operands and id onto the multiplier inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_v_q  <= 1'b0;
      issue_id_q <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
    end else begin
      issue_v_q <= grant_w;
      if (grant_w) begin
        issue_id_q <= grant_idx_w;
        mul_a_q    <= req_a_arr[grant_idx_w];
        mul_b_q    <= req_b_arr[grant_idx_w];
      end
    end
  end

  assign mul_in_valid = issue_v_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;

  // --------------------------------------------------------------------------
  // Tag pipeline
  // --------------------------------------------------------------------------

  generate
    for (genvar gs = 1; gs <= MUL_LATENCY; gs++) begin : g_tag
      if (gs == 1) begin : g_head
        // First tag stage follows the issue register.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            tag_v_q[gs]  <= 1'b0;
            tag_id_q[gs] <= '0;
          end else begin
            tag_v_q[gs]  <= issue_v_q;
            tag_id_q[gs] <= issue_id_q;
          end
        end
      end else begin : g_body
        // Later tag stages shift in lockstep with the multiplier pipeline.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            tag_v_q[gs]  <= 1'b0;
            tag_id_q[gs] <= '0;
          end else begin
            tag_v_q[gs]  <= tag_v_q[gs-1];
            tag_id_q[gs] <= tag_id_q[gs-1];
          end
        end
      end
    end
  endgenerate

  // Decode the tail id into a one-hot result strobe.
  always_comb begin
    tail_v_w      = tag_v_q[MUL_LATENCY];
    tail_id_w     = tag_id_q[MUL_LATENCY];
    tail_onehot_w = '0;
    tail_onehot_w[tail_id_w] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Result register and checker
  // --------------------------------------------------------------------------

  // The tag tail, not mul_out_valid, decides when a product is delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= '0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= tail_v_w ? tail_onehot_w : '0;
      if (tail_v_w) begin
        res_data_q <= mul_c;
      end
    end
  end

  // Sticky flag when the multiplier's valid disagrees with the tag tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (run_w && (mul_out_valid != tail_v_w)) begin
      err_q <= 1'b1;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_single_multiply_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_single_multiply_arbiter
// Description : Self-checking bench for single_multiply_arbiter with a
//               behavioural multiplier and a queue-based result model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_single_multiply_arbiter;

  localparam int N = 4;
  localparam int L = 2;
  localparam int H = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [N-1:0]   res_valid;
  logic [31:0]    res_data;
  logic           mul_rstn;
  logic           mul_in_valid;
  logic [31:0]    mul_a;
  logic [31:0]    mul_b;
  logic           mul_out_valid;
  logic [31:0]    mul_c;
  logic           err;
  logic           force_ov = 1'b0;

  single_multiply_arbiter #(.N_REQ(N), .MUL_LATENCY(L), .RST_HOLD(H)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_data(res_data),
    .mul_rstn(mul_rstn), .mul_in_valid(mul_in_valid),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_out_valid(mul_out_valid), .mul_c(mul_c),
    .err(err)
  );

  always #5 clk = ~clk;

  // Simplified single-precision product (truncating, normal numbers).
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {s, e[7:0], m};
  endfunction

  // Behavioural 2-stage multiplier
  logic        s1_v = 1'b0, s2_v = 1'b0;
  logic [31:0] s1_c = '0,   s2_c = '0;
  always @(posedge clk) begin
    s1_v <= mul_in_valid;
    s1_c <= fmul(mul_a, mul_b);
    s2_v <= s1_v;
    s2_c <= s1_c;
  end
  assign mul_out_valid = s2_v | force_ov;
  assign mul_c         = s2_c;

  // Reference model state
  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } res_t;

  res_t        q[$];
  int          ptr;
  int          holdcnt;
  int          cyc = 0;
  bit          exp_iv;
  bit          exp_err;
  logic [31:0] last_a, last_b, last_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare all outputs for the current cycle, then advance the model.
  task automatic check_cycle(input bit use_lit, input logic [31:0] lit);
    bit          run;
    int          g;
    int          i;
    logic [N-1:0] er;
    logic [N-1:0] erv;
    res_t        r;
    run = (holdcnt == 0) && !rst;
    g   = -1;
    er  = '0;
    if (run) begin
      for (int k = 0; k < N; k++) begin
        i = (ptr + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("mul_rstn", mul_rstn, run);
    chk("mul_in_valid", mul_in_valid, exp_iv);
    chk("mul_a", mul_a, last_a);
    chk("mul_b", mul_b, last_b);
    erv = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      erv[r.id] = 1'b1;
      last_data = r.data;
    end
    chk("res_valid", res_valid, erv);
    chk("res_data", res_data, last_data);
    chk("err", err, exp_err);
    if (run && force_ov) exp_err = 1'b1;
    if (g >= 0) begin
      ptr    = (g + 1) % N;
      last_a = req_a[32*g +: 32];
      last_b = req_b[32*g +: 32];
      r.id   = g;
      r.data = use_lit ? lit : fmul(last_a, last_b);
      r.due  = cyc + L + 2;
      q.push_back(r);
      exp_iv = 1'b1;
    end else begin
      exp_iv = 1'b0;
    end
  endtask

  task automatic step(input logic [N-1:0] vld, input logic [32*N-1:0] a, input logic [32*N-1:0] b,
                      input bit use_lit, input logic [31:0] lit, input bit frc);
    @(posedge clk);
    cyc++;
    if (holdcnt > 0) holdcnt--;
    #1;
    req_valid = vld;
    req_a     = a;
    req_b     = b;
    force_ov  = frc;
    @(negedge clk);
    check_cycle(use_lit, lit);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, req_a, req_b, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset(input logic [N-1:0] vld);
    @(posedge clk);
    cyc++;
    #1;
    rst       = 1'b1;
    req_valid = vld;
    force_ov  = 1'b0;
    q.delete();
    ptr       = 0;
    exp_iv    = 1'b0;
    exp_err   = 1'b0;
    last_a    = '0;
    last_b    = '0;
    last_data = '0;
    holdcnt   = H;
    #1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_res_valid", res_valid, '0);
    chk("rst_res_data", res_data, '0);
    chk("rst_mul_rstn", mul_rstn, 1'b0);
    chk("rst_mul_in_valid", mul_in_valid, 1'b0);
    chk("rst_mul_a", mul_a, '0);
    chk("rst_mul_b", mul_b, '0);
    chk("rst_err", err, 1'b0);
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    rst     = 1'b0;
    holdcnt = H;
    @(negedge clk);
    check_cycle(1'b0, 32'h0);
  endtask

  typedef struct {
    logic [N-1:0]    vld;
    logic [32*N-1:0] a;
    logic [32*N-1:0] b;
    logic [N-1:0]    exp_ready;
    logic [31:0]     exp_prod;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [32*N-1:0] a4, b2, z;
    vec_t v;
    a4 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    b2 = {4{32'h40000000}};
    z  = '0;

    // Full contention from ptr 0: grants 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      v.vld = 4'hF; v.a = a4; v.b = b2; v.exp_ready = 4'b0001 << (k % 4);
      case (k % 4)
        0: v.exp_prod = 32'h40000000;
        1: v.exp_prod = 32'h40800000;
        2: v.exp_prod = 32'h40C00000;
        default: v.exp_prod = 32'h41000000;
      endcase
      tbl.push_back(v);
    end
    for (int k = 0; k < 5; k++) begin
      v.vld = '0; v.a = z; v.b = z; v.exp_ready = '0; v.exp_prod = '0; tbl.push_back(v);
    end
    // Single op from requester 2: 3.0 * 2.0
    v.vld = 4'b0100; v.a = {32'h0, 32'h40400000, 64'h0}; v.b = {32'h0, 32'h40000000, 64'h0};
    v.exp_ready = 4'b0100; v.exp_prod = 32'h40C00000; tbl.push_back(v);
    for (int k = 0; k < 5; k++) begin
      v.vld = '0; v.a = z; v.b = z; v.exp_ready = '0; v.exp_prod = '0; tbl.push_back(v);
    end
    // Zero operand from requester 1, idle, then -1.0 * 1.0 from requester 3
    v.vld = 4'b0010; v.a = z; v.b = {64'h0, 32'h40400000, 32'h0};
    v.exp_ready = 4'b0010; v.exp_prod = 32'h00000000; tbl.push_back(v);
    v.vld = '0; v.a = z; v.b = z; v.exp_ready = '0; v.exp_prod = '0; tbl.push_back(v);
    v.vld = 4'b1000; v.a = {32'hBF800000, 96'h0}; v.b = {32'h3F800000, 96'h0};
    v.exp_ready = 4'b1000; v.exp_prod = 32'hBF800000; tbl.push_back(v);
    for (int k = 0; k < 5; k++) begin
      v.vld = '0; v.a = z; v.b = z; v.exp_ready = '0; v.exp_prod = '0; tbl.push_back(v);
    end
    // Sparse pair: ptr 0 picks 0, then ptr 1 skips to 2
    v.vld = 4'b0101; v.a = a4; v.b = b2; v.exp_ready = 4'b0001; v.exp_prod = 32'h40000000; tbl.push_back(v);
    v.vld = 4'b0101; v.a = a4; v.b = b2; v.exp_ready = 4'b0100; v.exp_prod = 32'h40C00000; tbl.push_back(v);
    for (int k = 0; k < 5; k++) begin
      v.vld = '0; v.a = z; v.b = z; v.exp_ready = '0; v.exp_prod = '0; tbl.push_back(v);
    end

    // Reset release with all requesters asking during the hold window
    do_reset(4'hF);
    step(4'hF, a4, b2, 1'b0, 32'h0, 1'b0);

    // Directed vectors
    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].a, tbl[i].b, 1'b1, tbl[i].exp_prod, 1'b0);
      chk("tbl_ready", req_ready, tbl[i].exp_ready);
    end

    // Reset with two operations in flight
    step(4'b0001, a4, b2, 1'b0, 32'h0, 1'b0);
    step(4'b0010, a4, b2, 1'b0, 32'h0, 1'b0);
    do_reset('0);
    idle(1);
    step(4'b0100, {32'h0, 32'h40400000, 64'h0}, {32'h0, 32'h40000000, 64'h0}, 1'b1, 32'h40C00000, 1'b0);
    idle(6);

    // Spurious multiplier valid with an empty tag pipeline
    step('0, z, z, 1'b0, 32'h0, 1'b1);
    idle(4);
    do_reset('0);
    idle(2);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(N'($urandom_range(0, 15)),
           {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom},
           1'b0, 32'h0, 1'b0);
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
